pc_reg_ctrl: RTL and testbench

- Program-counter register and run/halt controller for the fetch stage.
- Sits directly downstream of the next-PC 2:1 mux (sequential PC vs. jump/branch target): it registers the mux output as the architectural PC, which then drives instruction-memory addressing and the PC+4 input of that same mux.
- Also holds the performance counters shown on the board display: total cycles, unconditional jumps, taken conditional branches.

---
 rtl/pc_reg_ctrl_pkg.sv | 12 +
 rtl/pc_reg_ctrl_sat_counter.sv | 19 +
 rtl/pc_reg_ctrl.sv | 84 ++++++++
 tb/tb_pc_reg_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pc_reg_ctrl_pkg.sv
// Shared fetch-stage definitions: run/halt state encoding, reset PC default and PC step.
package pc_reg_ctrl_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned PC_INC           = 4;

endpackage

// File: rtl/pc_reg_ctrl_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pc_reg_ctrl.sv
// Architectural PC register with a RUN/HALT controller and saturating statistics counters.
module pc_reg_ctrl
    import pc_reg_ctrl_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(DEFAULT_RESET_PC),
    parameter int               CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     next_pc,
    input  logic                 stall,
    input  logic                 halt_req,
    input  logic                 go,
    input  logic                 is_jump,
    input  logic                 is_branch_taken,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     pc_plus4,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] jump_cnt,
    output logic [CNT_WIDTH-1:0] branch_cnt
);

    localparam logic [0:0] ST_RUN  = 1'(RUN);
    localparam logic [0:0] ST_HALT = 1'(HALT);

    logic [0:0] state;
    logic       in_run;
    logic       advance;

    assign in_run   = (state == ST_RUN);
    assign advance  = in_run && !halt_req && !stall;
    assign pc_plus4 = pc + WIDTH'(PC_INC);
    // halted is a straight decode of the state flop, so it is registered and doubles as state visibility.
    assign halted   = (state == ST_HALT);

    // In RUN a halt wins over a stall; in HALT only go matters, and it also loads next_pc
    // so the halting instruction is stepped over and cannot re-trigger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt_req) begin
                        state <= ST_HALT;
                    end else if (!stall) begin
                        pc <= next_pc;
                    end
                end
                default: begin
                    if (go) begin
                        pc    <= next_pc;
                        state <= ST_RUN;
                    end
                end
            endcase
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (in_run),
        .count (cycle_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_jump_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (advance && is_jump),
        .count (jump_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_branch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (advance && is_branch_taken),
        .count (branch_cnt)
    );

endmodule

// File: tb/tb_pc_reg_ctrl.sv
// Directed bench for pc_reg_ctrl: a default build for PC/FSM behaviour and a narrow-counter,
// top-of-memory build for saturation and pc_plus4 wrap.
module tb_pc_reg_ctrl;

    logic clk;

    // default build
    logic        rst;
    logic [31:0] next_pc;
    logic        stall, halt_req, go, is_jump, is_branch_taken;
    logic [31:0] pc, pc_plus4;
    logic        halted;
    logic [31:0] cycle_cnt, jump_cnt, branch_cnt;

    // CNT_WIDTH=4, RESET_PC=FFFF_FFFC build
    logic        rst1;
    logic [31:0] next_pc1;
    logic        stall1, halt_req1, go1, is_jump1, is_branch_taken1;
    logic [31:0] pc1, pc_plus4_1;
    logic        halted1;
    logic [3:0]  cycle_cnt1, jump_cnt1, branch_cnt1;

    int n_checks = 0;
    int n_pass   = 0;

    pc_reg_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .next_pc         (next_pc),
        .stall           (stall),
        .halt_req        (halt_req),
        .go              (go),
        .is_jump         (is_jump),
        .is_branch_taken (is_branch_taken),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .halted          (halted),
        .cycle_cnt       (cycle_cnt),
        .jump_cnt        (jump_cnt),
        .branch_cnt      (branch_cnt)
    );

    pc_reg_ctrl #(
        .WIDTH     (32),
        .RESET_PC  (32'hFFFF_FFFC),
        .CNT_WIDTH (4)
    ) dut_small (
        .clk             (clk),
        .rst             (rst1),
        .next_pc         (next_pc1),
        .stall           (stall1),
        .halt_req        (halt_req1),
        .go              (go1),
        .is_jump         (is_jump1),
        .is_branch_taken (is_branch_taken1),
        .pc              (pc1),
        .pc_plus4        (pc_plus4_1),
        .halted          (halted1),
        .cycle_cnt       (cycle_cnt1),
        .jump_cnt        (jump_cnt1),
        .branch_cnt      (branch_cnt1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, then settle so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] npc, input logic st, input logic hr,
                         input logic g, input logic j, input logic b);
        next_pc         = npc;
        stall           = st;
        halt_req        = hr;
        go              = g;
        is_jump         = j;
        is_branch_taken = b;
    endtask

    task automatic check_main(input string tag, input logic [31:0] e_pc, input logic e_halted,
                              input logic [31:0] e_cyc, input logic [31:0] e_jmp,
                              input logic [31:0] e_br);
        check({tag, ".pc"},     64'(pc),         64'(e_pc));
        check({tag, ".halted"}, 64'(halted),     64'(e_halted));
        check({tag, ".cycle"},  64'(cycle_cnt),  64'(e_cyc));
        check({tag, ".jump"},   64'(jump_cnt),   64'(e_jmp));
        check({tag, ".branch"}, 64'(branch_cnt), 64'(e_br));
    endtask

    initial begin
        rst = 1'b1;
        rst1 = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        next_pc1 = 32'h0; stall1 = 1'b0; halt_req1 = 1'b0; go1 = 1'b0;
        is_jump1 = 1'b0; is_branch_taken1 = 1'b0;
        #1;
        check_main("reset", 32'h0, 1'b0, 32'd0, 32'd0, 32'd0);
        check("reset.pc_plus4", 64'(pc_plus4), 64'h4);
        @(negedge clk);
        rst = 1'b0;

        // free run, next_pc follows pc+4
        for (int i = 1; i <= 3; i++) begin
            drive(32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
            check($sformatf("run%0d.pc", i), 64'(pc), 64'(4 * i));
            check($sformatf("run%0d.plus4", i), 64'(pc_plus4), 64'(4 * i + 4));
        end
        check_main("run3", 32'd12, 1'b0, 32'd3, 32'd0, 32'd0);

        // stall holds pc and blocks the jump count, but cycles still count
        drive(32'h99, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        check_main("stall1", 32'd12, 1'b0, 32'd4, 32'd0, 32'd0);
        step();
        check_main("stall2", 32'd12, 1'b0, 32'd5, 32'd0, 32'd0);
        drive(32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        check_main("jump", 32'h40, 1'b0, 32'd6, 32'd1, 32'd0);

        // jump and taken-branch together: both counters move
        drive(32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        check_main("both", 32'h20, 1'b0, 32'd7, 32'd2, 32'd1);

        // halt overrides stall; halt cycle counts as a RUN cycle, not as a jump/branch
        drive(32'h77, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        check_main("halt", 32'h20, 1'b1, 32'd8, 32'd2, 32'd1);
        for (int i = 0; i < 10; i++) step();
        check_main("halt_hold", 32'h20, 1'b1, 32'd8, 32'd2, 32'd1);

        // go resumes and steps past the halt instruction in one edge
        drive(32'h24, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check_main("go", 32'h24, 1'b0, 32'd8, 32'd2, 32'd1);

        // go while running is just an ordinary advance
        drive(32'h100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        check_main("go_run", 32'h100, 1'b0, 32'd9, 32'd2, 32'd2);

        drive(32'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check_main("halt2", 32'h100, 1'b1, 32'd10, 32'd2, 32'd2);

        // async reset mid-halt, between clock edges
        #2;
        rst = 1'b1;
        #1;
        check_main("async_rst", 32'h0, 1'b0, 32'd0, 32'd0, 32'd0);
        #2;
        rst = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // small build: wrap of pc_plus4 at top of memory, then counter saturation
        check("wrap.pc_rst", 64'(pc1), 64'hFFFF_FFFC);
        check("wrap.plus4_rst", 64'(pc_plus4_1), 64'h0);
        @(negedge clk);
        rst1 = 1'b0;
        next_pc1 = 32'h0;
        step();
        check("wrap.pc", 64'(pc1), 64'h0);
        check("wrap.cycle", 64'(cycle_cnt1), 64'h1);
        is_branch_taken1 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            next_pc1 = 32'(4 * i);
            step();
            if (i == 14) begin
                check("sat14.branch", 64'(branch_cnt1), 64'hE);
                check("sat14.cycle", 64'(cycle_cnt1), 64'hF);
            end
        end
        check("sat.branch", 64'(branch_cnt1), 64'hF);
        check("sat.cycle", 64'(cycle_cnt1), 64'hF);
        check("sat.jump", 64'(jump_cnt1), 64'h0);
        check("sat.pc", 64'(pc1), 64'h50);
        check("sat.halted", 64'(halted1), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
